period_sweep_ctrl: RTL

Sequencer for the 11-bit counter/LFSR benchmark datapath (start/stop/mode[1:0] control, counter_out[10:0] observation). On a `go` request it steps the target through modes FIRST_MODE..LAST_MODE. For each mode it starts the target, measures the sequence period in clock cycles by detecting the return of the output to its first sampled value, reports one result per mode, then stops the target. It replaces the hand-timed testbench stimulus with a self-timed, self-checking measurement engine.

---
 rtl/sweep_pkg.sv | 14 +
 rtl/period_meter.sv | 48 ++++
 rtl/period_sweep_ctrl.sv | 135 +++++++++++++
 3 files changed

// File: rtl/sweep_pkg.sv
// Shared types and widths for the period sweep sequencer and its period meter.
package sweep_pkg;
  localparam int PERIOD_W = 12;
  localparam int DUT_W    = 11;

  localparam logic [1:0] MODE_8  = 2'b00;
  localparam logic [1:0] MODE_9  = 2'b01;
  localparam logic [1:0] MODE_10 = 2'b10;
  localparam logic [1:0] MODE_11 = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_CAPTURE, S_RUN, S_REPORT, S_HALT
  } sweep_state_t;
endpackage

// File: rtl/period_meter.sv
// Captures a reference sample, then counts cycles until the input returns to it.
module period_meter
  import sweep_pkg::*;
#(
  parameter logic [PERIOD_W-1:0] TIMEOUT = 12'd4095
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                capture,
  input  logic                enable,
  input  logic [DUT_W-1:0]    din,
  output logic                hit,
  output logic                tmo,
  output logic [PERIOD_W-1:0] period
);
  logic [DUT_W-1:0]    ref_val_q, ref_val_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;

  // A match in the same cycle as the limit wins, so tmo is masked by hit.
  assign hit    = enable && (din == ref_val_q);
  assign tmo    = enable && !hit && (cnt_q == TIMEOUT);
  assign period = hit ? cnt_q : '0;

  always_comb begin
    ref_val_d = ref_val_q;
    cnt_d     = cnt_q;
    if (clear) begin
      ref_val_d = '0;
      cnt_d     = '0;
    end else if (capture) begin
      ref_val_d = din;
      cnt_d     = PERIOD_W'(1);
    end else if (enable && !hit && !tmo) begin
      cnt_d = cnt_q + PERIOD_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_val_q <= '0;
      cnt_q     <= '0;
    end else begin
      ref_val_q <= ref_val_d;
      cnt_q     <= cnt_d;
    end
  end
endmodule

// File: rtl/period_sweep_ctrl.sv
// Steps a counter/LFSR target through its modes, measuring and reporting the
// output sequence period of each one.
module period_sweep_ctrl
  import sweep_pkg::*;
#(
  parameter logic [1:0]          FIRST_MODE = MODE_8,
  parameter logic [1:0]          LAST_MODE  = MODE_11,
  parameter logic [PERIOD_W-1:0] TIMEOUT    = 12'd4095
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                go,
  input  logic                abort,
  input  logic [DUT_W-1:0]    dut_out,
  output logic                dut_start,
  output logic                dut_stop,
  output logic [1:0]          dut_mode,
  output logic                busy,
  output logic                result_valid,
  output logic [1:0]          result_mode,
  output logic [PERIOD_W-1:0] result_period,
  output logic                timeout_err,
  output logic                done
);
  sweep_state_t        state_q, state_d;
  logic [1:0]          cur_mode_q, cur_mode_d;
  logic                abort_q, abort_d;
  logic                terr_q, terr_d;
  logic [1:0]          rmode_q, rmode_d;
  logic [PERIOD_W-1:0] rper_q, rper_d;
  logic                m_clear, m_capture, m_enable, m_hit, m_tmo;
  logic [PERIOD_W-1:0] m_period;

  period_meter #(.TIMEOUT(TIMEOUT)) u_meter (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (m_clear),
    .capture (m_capture),
    .enable  (m_enable),
    .din     (dut_out),
    .hit     (m_hit),
    .tmo     (m_tmo),
    .period  (m_period)
  );

  assign dut_mode      = cur_mode_q;
  assign busy          = (state_q != S_IDLE);
  assign timeout_err   = terr_q;
  assign result_mode   = rmode_q;
  assign result_period = rper_q;

  always_comb begin
    state_d      = state_q;
    cur_mode_d   = cur_mode_q;
    abort_d      = abort_q;
    terr_d       = terr_q;
    rmode_d      = rmode_q;
    rper_d       = rper_q;
    dut_start    = 1'b0;
    dut_stop     = 1'b0;
    result_valid = 1'b0;
    done         = 1'b0;
    m_clear      = 1'b0;
    m_capture    = 1'b0;
    m_enable     = 1'b0;
    case (state_q)
      S_IDLE: begin
        m_clear = 1'b1;
        if (go) begin
          state_d    = S_ARM;
          cur_mode_d = FIRST_MODE;
          terr_d     = 1'b0;
          abort_d    = 1'b0;
        end
      end
      S_ARM: begin
        dut_start = 1'b1;
        state_d   = abort ? S_HALT : S_CAPTURE;
        abort_d   = abort;
      end
      S_CAPTURE: begin
        m_capture = 1'b1;
        state_d   = abort ? S_HALT : S_RUN;
        abort_d   = abort;
      end
      S_RUN: begin
        m_enable = 1'b1;
        if (abort) begin
          state_d = S_HALT;
          abort_d = 1'b1;
        end else if (m_hit || m_tmo) begin
          state_d = S_REPORT;
          rmode_d = cur_mode_q;
          rper_d  = m_period;
          if (m_tmo) terr_d = 1'b1;
        end
      end
      S_REPORT: begin
        result_valid = 1'b1;
        state_d      = S_HALT;
        abort_d      = abort;
      end
      S_HALT: begin
        dut_stop = 1'b1;
        // An abort raised during HALT itself still ends the sweep here.
        if ((cur_mode_q == LAST_MODE) || abort_q || abort) begin
          state_d = S_IDLE;
          done    = !(abort_q || abort);
        end else begin
          state_d    = S_ARM;
          cur_mode_d = cur_mode_q + 2'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cur_mode_q <= FIRST_MODE;
      abort_q    <= 1'b0;
      terr_q     <= 1'b0;
      rmode_q    <= '0;
      rper_q     <= '0;
    end else begin
      state_q    <= state_d;
      cur_mode_q <= cur_mode_d;
      abort_q    <= abort_d;
      terr_q     <= terr_d;
      rmode_q    <= rmode_d;
      rper_q     <= rper_d;
    end
  end
endmodule
